// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update path.
// Holds the queued update entry and the default queue depth.
package bp_pkg;

    localparam int BP_UPD_DEPTH = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target;
        logic        taken;
        logic        dir_en;
        logic        btb_en;
    } bp_upd_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Two-write / one-read circular buffer of predictor updates.
// Full and empty are told apart by the occupancy count.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr0_en,
    input  bp_upd_t       i_wr0_data,
    input  logic          i_wr1_en,
    input  bp_upd_t       i_wr1_data,
    input  logic          i_rd_en,
    output bp_upd_t       o_head,
    output logic          o_head_vld,
    output logic [CW-1:0] o_occ
);

    bp_upd_t         r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_occ;
    logic [PW-1:0]   w_wr1_idx;
    logic [CW-1:0]   w_occ_nxt;

    // Lane 1 lands right behind lane 0 when both write, else at tail.
    assign w_wr1_idx = r_tail + PW'(i_wr0_en);
    assign w_occ_nxt = r_occ + CW'(i_wr0_en) + CW'(i_wr1_en)
                     - CW'(i_rd_en);

    assign o_head     = r_mem[r_head];
    assign o_head_vld = r_vld[r_head];
    assign o_occ      = r_occ;

    // Pointer, occupancy and entry-valid bookkeeping plus entry writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_vld  <= '0;
        end else begin
            if (i_wr0_en) begin
                r_mem[r_tail] <= i_wr0_data;
                r_vld[r_tail] <= 1'b1;
            end
            if (i_wr1_en) begin
                r_mem[w_wr1_idx] <= i_wr1_data;
                r_vld[w_wr1_idx] <= 1'b1;
            end
            if (i_rd_en) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PW'(1);
            end
            r_tail <= r_tail + PW'(i_wr0_en) + PW'(i_wr1_en);
            r_occ  <= w_occ_nxt;
        end
    end

endmodule

// File: rtl/bp_update_arbiter.sv
// Serialises two execute-lane branch resolutions onto the
// predictor's single update port, oldest first.
module bp_update_arbiter
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_UPD_DEPTH,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ex0_valid,
    input  logic [63:0]   ex0_pc,
    input  logic          ex0_taken,
    input  logic [63:0]   ex0_target,
    input  logic          ex0_cond,
    input  logic          ex0_wr_btb,
    input  logic          ex1_valid,
    input  logic [63:0]   ex1_pc,
    input  logic          ex1_taken,
    input  logic [63:0]   ex1_target,
    input  logic          ex1_cond,
    input  logic          ex1_wr_btb,
    output logic          ex_ready,
    input  logic          upd_stall,
    output logic          upd_valid,
    output logic [63:0]   upd_pc,
    output logic [63:0]   upd_target,
    output logic          upd_taken,
    output logic          upd_dir_en,
    output logic          upd_btb_en,
    output logic [CW-1:0] occupancy
);

    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    bp_upd_t       w_ent0;
    bp_upd_t       w_ent1;
    bp_upd_t       w_head;
    bp_upd_t       w_out;
    logic          w_head_vld;
    logic          w_push0;
    logic          w_push1;
    logic          w_pop;
    logic          w_ready;
    logic [CW-1:0] w_occ;

    // Two free slots guarantee both lanes fit; depends on state only.
    assign w_ready = (w_occ <= READY_MAX);

    // Offers needing neither table update are dropped outright.
    assign w_push0 = ex0_valid && w_ready && (ex0_cond || ex0_wr_btb);
    assign w_push1 = ex1_valid && w_ready && (ex1_cond || ex1_wr_btb);
    assign w_pop   = (w_occ != '0) && !upd_stall;

    assign w_ent0 = '{pc: ex0_pc, target: ex0_target, taken: ex0_taken,
                      dir_en: ex0_cond, btb_en: ex0_wr_btb};
    assign w_ent1 = '{pc: ex1_pc, target: ex1_target, taken: ex1_taken,
                      dir_en: ex1_cond, btb_en: ex1_wr_btb};

    bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_wr0_en   (w_push0),
        .i_wr0_data (w_ent0),
        .i_wr1_en   (w_push1),
        .i_wr1_data (w_ent1),
        .i_rd_en    (w_pop),
        .o_head     (w_head),
        .o_head_vld (w_head_vld),
        .o_occ      (w_occ)
    );

    // Head data is zeroed whenever the head slot holds nothing.
    always_comb begin
        w_out = '0;
        if (w_head_vld) begin
            w_out = w_head;
        end
    end

    assign ex_ready   = w_ready;
    assign upd_valid  = w_pop;
    assign upd_pc     = w_out.pc;
    assign upd_target = w_out.target;
    assign upd_taken  = w_out.taken;
    assign upd_dir_en = w_out.dir_en;
    assign upd_btb_en = w_out.btb_en;
    assign occupancy  = w_occ;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Directed bench for bp_update_arbiter.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_bp_update_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex0_valid, ex0_taken, ex0_cond, ex0_wr_btb;
    logic        ex1_valid, ex1_taken, ex1_cond, ex1_wr_btb;
    logic [63:0] ex0_pc, ex0_target, ex1_pc, ex1_target;
    logic        ex_ready, upd_stall, upd_valid;
    logic [63:0] upd_pc, upd_target;
    logic        upd_taken, upd_dir_en, upd_btb_en;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    bp_update_arbiter #(.DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .ex0_valid  (ex0_valid),
        .ex0_pc     (ex0_pc),
        .ex0_taken  (ex0_taken),
        .ex0_target (ex0_target),
        .ex0_cond   (ex0_cond),
        .ex0_wr_btb (ex0_wr_btb),
        .ex1_valid  (ex1_valid),
        .ex1_pc     (ex1_pc),
        .ex1_taken  (ex1_taken),
        .ex1_target (ex1_target),
        .ex1_cond   (ex1_cond),
        .ex1_wr_btb (ex1_wr_btb),
        .ex_ready   (ex_ready),
        .upd_stall  (upd_stall),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .upd_dir_en (upd_dir_en),
        .upd_btb_en (upd_btb_en),
        .occupancy  (occupancy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer0(input logic [63:0] pc, input logic tk,
                          input logic [63:0] tg, input logic c,
                          input logic b);
        ex0_valid = 1'b1; ex0_pc = pc; ex0_taken = tk;
        ex0_target = tg; ex0_cond = c; ex0_wr_btb = b;
    endtask

    task automatic offer1(input logic [63:0] pc, input logic tk,
                          input logic [63:0] tg, input logic c,
                          input logic b);
        ex1_valid = 1'b1; ex1_pc = pc; ex1_taken = tk;
        ex1_target = tg; ex1_cond = c; ex1_wr_btb = b;
    endtask

    task automatic idle();
        ex0_valid = 0; ex0_pc = 0; ex0_taken = 0;
        ex0_target = 0; ex0_cond = 0; ex0_wr_btb = 0;
        ex1_valid = 0; ex1_pc = 0; ex1_taken = 0;
        ex1_target = 0; ex1_cond = 0; ex1_wr_btb = 0;
    endtask

    initial begin
        idle();
        upd_stall = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        chk("rst_valid", 64'(upd_valid), 64'd0);
        chk("rst_ready", 64'(ex_ready), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_pc", upd_pc, 64'd0);
        chk("rst_tgt", upd_target, 64'd0);
        chk("rst_flags", {61'd0, upd_taken, upd_dir_en, upd_btb_en}, 64'd0);

        // single update
        offer0(64'h100, 1'b1, 64'h200, 1'b1, 1'b1);
        tick();
        idle();
        chk("one_valid", 64'(upd_valid), 64'd1);
        chk("one_pc", upd_pc, 64'h100);
        chk("one_tgt", upd_target, 64'h200);
        chk("one_flags", {61'd0, upd_taken, upd_dir_en, upd_btb_en}, 64'd7);
        chk("one_occ", 64'(occupancy), 64'd1);
        tick();
        chk("one_drain_occ", 64'(occupancy), 64'd0);
        chk("one_drain_valid", 64'(upd_valid), 64'd0);

        // ordering across lanes and cycles
        offer0(64'h10, 1'b0, 64'h0, 1'b1, 1'b0);
        offer1(64'h14, 1'b1, 64'h50, 1'b1, 1'b0);
        tick();
        idle();
        offer0(64'h18, 1'b1, 64'h60, 1'b0, 1'b1);
        chk("ord_pc0", upd_pc, 64'h10);
        chk("ord_occ0", 64'(occupancy), 64'd2);
        chk("ord_ready0", 64'(ex_ready), 64'd1);
        tick();
        idle();
        chk("ord_pc1", upd_pc, 64'h14);
        chk("ord_flags1", {61'd0, upd_taken, upd_dir_en, upd_btb_en}, 64'd6);
        chk("ord_occ1", 64'(occupancy), 64'd2);
        tick();
        chk("ord_pc2", upd_pc, 64'h18);
        chk("ord_tgt2", upd_target, 64'h60);
        chk("ord_flags2", {61'd0, upd_taken, upd_dir_en, upd_btb_en}, 64'd5);
        tick();
        chk("ord_empty", 64'(occupancy), 64'd0);

        // fill under stall, then drain
        upd_stall = 1'b1;
        offer0(64'h20, 1'b0, 64'h0, 1'b1, 1'b1);
        offer1(64'h24, 1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        chk("full_occ2", 64'(occupancy), 64'd2);
        chk("full_stall_valid", 64'(upd_valid), 64'd0);
        chk("full_stall_pc", upd_pc, 64'h20);
        offer0(64'h28, 1'b0, 64'h0, 1'b1, 1'b1);
        offer1(64'h2c, 1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        chk("full_occ4", 64'(occupancy), 64'd4);
        chk("full_ready", 64'(ex_ready), 64'd0);
        offer0(64'h30, 1'b0, 64'h0, 1'b1, 1'b1);
        offer1(64'h34, 1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        idle();
        chk("full_ignored_occ", 64'(occupancy), 64'd4);
        chk("full_hold_pc", upd_pc, 64'h20);
        upd_stall = 1'b0;
        #1;
        chk("drain_valid0", 64'(upd_valid), 64'd1);
        tick();
        chk("drain_pc1", upd_pc, 64'h24);
        chk("drain_occ3", 64'(occupancy), 64'd3);
        chk("drain_ready3", 64'(ex_ready), 64'd0);
        tick();
        chk("drain_pc2", upd_pc, 64'h28);
        chk("drain_ready2", 64'(ex_ready), 64'd1);
        tick();
        chk("drain_pc3", upd_pc, 64'h2c);
        tick();
        chk("drain_end_occ", 64'(occupancy), 64'd0);
        chk("drain_end_valid", 64'(upd_valid), 64'd0);
        chk("drain_end_pc", upd_pc, 64'd0);

        // drop of an offer needing no update
        offer1(64'h3c, 1'b1, 64'h77, 1'b0, 1'b0);
        tick();
        idle();
        chk("drop_occ", 64'(occupancy), 64'd0);
        chk("drop_valid", 64'(upd_valid), 64'd0);
        offer0(64'h44, 1'b1, 64'h0, 1'b0, 1'b0);
        offer1(64'h40, 1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        idle();
        chk("drop_l1_pc", upd_pc, 64'h40);
        chk("drop_l1_occ", 64'(occupancy), 64'd1);
        tick();

        // ten single pushes, each popped before the next, so pointers wrap
        for (int i = 0; i < 10; i++) begin
            offer0(64'h1000 + 64'(i * 4), 1'b1, 64'h0, 1'b1, 1'b0);
            tick();
            idle();
            chk($sformatf("wrap_pc%0d", i), upd_pc, 64'h1000 + 64'(i * 4));
            tick();
            chk($sformatf("wrap_occ%0d", i), 64'(occupancy), 64'd0);
        end

        // fill to three across the wrap boundary, then reset
        upd_stall = 1'b1;
        offer0(64'ha0, 1'b0, 64'h0, 1'b1, 1'b0);
        offer1(64'hb0, 1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        idle();
        offer0(64'hc0, 1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        idle();
        chk("pre_rst_occ", 64'(occupancy), 64'd3);
        chk("pre_rst_pc", upd_pc, 64'ha0);
        upd_stall = 1'b0;
        reset = 1'b1;
        offer0(64'hd0, 1'b1, 64'h0, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        idle();
        chk("mid_rst_valid", 64'(upd_valid), 64'd0);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_pc", upd_pc, 64'd0);
        chk("mid_rst_ready", 64'(ex_ready), 64'd1);
        tick();
        chk("post_rst_occ", 64'(occupancy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_update_arbiter.md
BP_UPDATE_ARBITER -- requirements
Module: bp_update_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, number of update-queue entries; legal values are powers of two and at least 2.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ex0_valid, ex1_valid  input  1 each  resolved-branch update offered by execute lane 0 / lane 1; lane 0 is always the older instruction.
REQ-005 ex0_pc, ex1_pc  input  64 each  PC of the resolved branch.
REQ-006 ex0_taken, ex1_taken  input  1 each  resolved direction: 1 = taken.
REQ-007 ex0_target, ex1_target  input  64 each  resolved target PC.
REQ-008 ex0_cond, ex1_cond  input  1 each  conditional branch; direction-table update is required.
REQ-009 ex0_wr_btb, ex1_wr_btb  input  1 each  target-buffer write is required.
REQ-010 ex_ready  output  1  both lanes may offer an update this cycle.
REQ-011 upd_stall  input  1  predictor cannot accept an update this cycle.
REQ-012 upd_valid  output  1  head update presented to the predictor this cycle.
REQ-013 upd_pc, upd_target  output  64 each  head entry PC and target.
REQ-014 upd_taken, upd_dir_en, upd_btb_en  output  1 each  head direction, direction-update enable, and target-write enable.
REQ-015 occupancy  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 Serialise up to two branch resolutions per cycle onto the predictor's single update port in strict program order, with lane 0 ahead of lane 1 and earlier cycles ahead of later ones.
REQ-017 A lane is accepted in cycle N when its exN_valid=1 and ex_ready=1; offers made while ex_ready=0 are ignored, and the producer holds them.
REQ-018 ex_ready = (DEPTH - occupancy) >= 2, evaluated from registered state only, with no combinational path from any input.
REQ-019 Drop an offer with both cond=0 and wr_btb=0: it is not enqueued and not counted.
REQ-020 Both lanes accepted in one cycle: lane 0 is written at tail and lane 1 at tail+1, modulo DEPTH; only lane 1 valid: it is written at tail.
REQ-021 upd_valid = (occupancy != 0) && !upd_stall; upd_pc, upd_target, upd_taken, upd_dir_en and upd_btb_en always reflect the head entry, and are 0 when the queue is empty.
REQ-022 Pop the head on every cycle with upd_valid=1; at most one pop per cycle.
REQ-023 Latency: an entry accepted in cycle N is visible at the head no earlier than cycle N+1; there is no input-to-output bypass.
REQ-024 Push and pop in the same cycle: next occupancy = occupancy + pushes - pop; a push into the slot freed by the pop is not permitted because ex_ready was computed from pre-pop occupancy.
REQ-025 Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full and empty are distinguished by occupancy, not pointer equality.
REQ-026 A pipeline flush does not affect this block: resolved updates are architecturally valid and are always drained.
REQ-027 upd_stall=1 holds the head entry and outputs unchanged, and enqueueing continues while space allows.

Reset
REQ-028 On reset=1 at a clock edge: head=0, tail=0, occupancy=0, all entry valid state cleared; the cycle after reset gives upd_valid=0, ex_ready=1, and all upd_* data outputs 0.
REQ-029 Reset asserted mid-operation discards all queued updates without presenting them, and any same-cycle offers are not accepted.

Structure
REQ-030 The shared package bp_pkg holds the update-entry struct bp_upd_t (pc, target, taken, dir_en, btb_en) and the constant BP_UPD_DEPTH=4.
REQ-031 Storage is one sub-module, bp_upd_fifo: a 2-write/1-read circular buffer of bp_upd_t. The arbiter holds the accept/drop logic and the output gating.

Verification
REQ-032 Single update: reset, then ex0_valid=1, pc=0x100, taken=1, target=0x200, cond=1, wr_btb=1 for one cycle -> next cycle upd_valid=1, upd_pc=0x100, upd_target=0x200; following cycle occupancy=0.
REQ-033 Ordering: ex0 pc=0x10 and ex1 pc=0x14 in the same cycle, followed by ex0 pc=0x18 -> upd_pc sequence 0x10, 0x14, 0x18 on consecutive cycles.
REQ-034 Full with DEPTH=4 and upd_stall=1: two dual-lane pushes -> occupancy=4, ex_ready=0; a third offer is ignored; release the stall -> exactly 4 updates drain, with ex_ready=1 once occupancy<=2.
REQ-035 Drop: ex1_valid=1 with cond=0 and wr_btb=0 -> occupancy unchanged and upd_valid stays 0.
REQ-036 Wrap and reset: 10 single pushes interleaved with pops verify head and tail wrap; then assert reset with occupancy=3 -> next cycle upd_valid=0 and occupancy=0.
